alu_resp_packer: RTL

//  Response-side packetizer for the UART ALU. Takes one ALU result (opcode + 64-bit data) and serializes it

---
 rtl/alu_resp_packer_pkg.sv | 27 ++
 rtl/alu_resp_packer_byte_mux.sv | 36 +++
 rtl/alu_resp_packer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_resp_packer_pkg.sv
// Shared opcodes, header size and response FSM state type for the ALU response packer.
package alu_resp_packer_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAC;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    localparam int unsigned RESP_HDR_BYTES = 4;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_HDR,
        RESP_PAYLOAD,
        RESP_CSUM
    } resp_state_e;

    // Payload bytes carried for a given opcode; unknown opcodes send a bare header.
    function automatic logic [3:0] payload_bytes(input logic [7:0] op);
        case (op)
            OP_ADD, OP_DIV, OP_ECHO: payload_bytes = 4'd4;
            OP_MUL:                  payload_bytes = 4'd8;
            default:                 payload_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_resp_packer_byte_mux.sv
// resp_byte_mux: selects the outgoing response byte from the captured packet fields.
module resp_byte_mux
    import alu_resp_packer_pkg::*;
#(
    parameter int unsigned RESULT_W  = 64,
    parameter logic [7:0]  RSVD_BYTE = 8'h00
) (
    input  logic [1:0]          state_i,
    input  logic [1:0]          hdr_idx_i,
    input  logic [2:0]          pay_idx_i,
    input  logic [7:0]          opcode_i,
    input  logic [15:0]         len_i,
    input  logic [RESULT_W-1:0] result_i,
    input  logic [7:0]          csum_i,
    output logic [7:0]          tx_data_o
);

    always_comb begin
        tx_data_o = '0;
        case (resp_state_e'(state_i))
            RESP_HDR: begin
                case (hdr_idx_i)
                    2'd0:    tx_data_o = opcode_i;
                    2'd1:    tx_data_o = RSVD_BYTE;
                    2'd2:    tx_data_o = len_i[7:0];
                    default: tx_data_o = len_i[15:8];
                endcase
            end
            // Payload goes out little-endian: index 0 is result[7:0].
            RESP_PAYLOAD: tx_data_o = result_i[{pay_idx_i, 3'b000} +: 8];
            RESP_CSUM:    tx_data_o = csum_i;
            default:      tx_data_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_resp_packer.sv
// alu_resp_packer: frames one ALU result as [opcode][rsvd][len LE][payload LE] toward UART TX.
// Define ALU_RESP_CHECKSUM_EN to append an XOR trailer byte over the whole packet.
module alu_resp_packer
    import alu_resp_packer_pkg::*;
#(
    parameter int unsigned RESULT_W  = 64,
    parameter logic [7:0]  RSVD_BYTE = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                result_valid_i,
    output logic                result_ready_o,
    input  logic [7:0]          opcode_i,
    input  logic [RESULT_W-1:0] result_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                busy_o
);

`ifdef ALU_RESP_CHECKSUM_EN
    localparam logic [15:0] TRAILER_BYTES = 16'd1;
    localparam resp_state_e AFTER_DATA    = RESP_CSUM;
`else
    localparam logic [15:0] TRAILER_BYTES = 16'd0;
    localparam resp_state_e AFTER_DATA    = RESP_IDLE;
`endif

    resp_state_e         state_q, state_d;
    logic [1:0]          hdr_idx_q, hdr_idx_d;
    logic [2:0]          pay_idx_q, pay_idx_d;
    logic [3:0]          plen_q, plen_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [7:0]          csum_q;
    logic [15:0]         len_w;
    logic                accept;
    logic                xfer;
    logic                pay_last;

`ifdef ALU_RESP_CHECKSUM_EN
    logic [7:0] csum_d;
`else
    assign csum_q = '0;
`endif

    assign len_w    = 16'(RESP_HDR_BYTES) + {12'd0, plen_q} + TRAILER_BYTES;
    assign accept   = (state_q == RESP_IDLE) && result_valid_i;
    assign xfer     = (state_q != RESP_IDLE) && tx_ready_i;
    // Compared against the captured length so a changing opcode_i cannot shorten the packet.
    assign pay_last = (pay_idx_q == 3'(plen_q - 4'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RESP_IDLE;
            hdr_idx_q <= '0;
            pay_idx_q <= '0;
            plen_q    <= '0;
            opcode_q  <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            pay_idx_q <= pay_idx_d;
            plen_q    <= plen_d;
            opcode_q  <= opcode_d;
            result_q  <= result_d;
        end
    end

`ifdef ALU_RESP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = '0;
        end else if (xfer && (state_q != RESP_CSUM)) begin
            csum_d = csum_q ^ tx_data_o;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        pay_idx_d = pay_idx_q;
        plen_d    = plen_q;
        opcode_d  = opcode_q;
        result_d  = result_q;
        case (state_q)
            RESP_IDLE: begin
                if (accept) begin
                    state_d   = RESP_HDR;
                    hdr_idx_d = '0;
                    pay_idx_d = '0;
                    plen_d    = payload_bytes(opcode_i);
                    opcode_d  = opcode_i;
                    result_d  = result_i;
                end
            end
            RESP_HDR: begin
                if (xfer) begin
                    if (hdr_idx_q == 2'd3) begin
                        state_d = (plen_q != 4'd0) ? RESP_PAYLOAD : AFTER_DATA;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            RESP_PAYLOAD: begin
                if (xfer) begin
                    if (pay_last) begin
                        state_d = AFTER_DATA;
                    end else begin
                        pay_idx_d = pay_idx_q + 3'd1;
                    end
                end
            end
`ifdef ALU_RESP_CHECKSUM_EN
            RESP_CSUM: begin
                if (xfer) begin
                    state_d = RESP_IDLE;
                end
            end
`endif
            default: state_d = RESP_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_o     = (state_q != RESP_IDLE);
        busy_o         = (state_q != RESP_IDLE);
        result_ready_o = (state_q == RESP_IDLE);
    end

    resp_byte_mux #(
        .RESULT_W  (RESULT_W),
        .RSVD_BYTE (RSVD_BYTE)
    ) u_byte_mux (
        .state_i   (state_q),
        .hdr_idx_i (hdr_idx_q),
        .pay_idx_i (pay_idx_q),
        .opcode_i  (opcode_q),
        .len_i     (len_w),
        .result_i  (result_q),
        .csum_i    (csum_q),
        .tx_data_o (tx_data_o)
    );

endmodule
